la_capture_ctrl: RTL and testbench

//  Acquisition sequencer for the logic-analyzer sample FIFO/BRAM. Drives acquire/pop/clear so the

---
 rtl/la_ctrl_pkg.sv | 23 ++
 rtl/la_ctrl_regs.sv | 85 ++++++++
 rtl/la_capture_ctrl.sv | 155 +++++++++++++++
 tb/tb_la_capture_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_ctrl_pkg.sv
// Shared definitions for the logic-analyzer capture sequencer: state encoding,
// register window offsets and STATUS bit layout.
package la_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MOVE      = 3'd1,
      ST_IN_POS    = 3'd2,
      ST_CAPTURING = 3'd3,
      ST_CAPTURED  = 3'd4
   } la_state_t;

   localparam logic [2:0] REG_STATE    = 3'd0;
   localparam logic [2:0] REG_TRIG_LOC = 3'd1;
   localparam logic [2:0] REG_START    = 3'd2;
   localparam logic [2:0] REG_STOP     = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;
   localparam int         NUM_REGS     = 5;

   localparam int STATUS_TIMED_OUT_BIT = 0;
   localparam int STATUS_FIFO_LSB      = 1;

endpackage

// File: rtl/la_ctrl_regs.sv
// Register-bus stage for la_capture_ctrl: one-cycle bus pipeline, window decode,
// TRIGGER_LOC storage, START/STOP strobes and readback.
module la_ctrl_regs
   import la_ctrl_pkg::*;
#(
   parameter int BASE_ADDR    = 0,
   parameter int SAMPLE_DEPTH = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [15:0]                       addr_i,
   input  logic [15:0]                       wdata_i,
   input  logic [15:0]                       rdata_i,
   input  logic                              rw_i,
   input  logic                              valid_i,
   output logic [15:0]                       addr_o,
   output logic [15:0]                       wdata_o,
   output logic [15:0]                       rdata_o,
   output logic                              rw_o,
   output logic                              valid_o,
   input  logic [2:0]                        state,
   input  logic                              timed_out,
   input  logic [$clog2(SAMPLE_DEPTH):0]     fifo_size,
   output logic [$clog2(SAMPLE_DEPTH):0]     trigger_loc,
   output logic                              start,
   output logic                              stop
);

   localparam int AW = $clog2(SAMPLE_DEPTH);
   typedef logic [AW:0] cnt_t;

   localparam logic [16:0] WIN_LO   = 17'(BASE_ADDR);
   localparam logic [16:0] WIN_HI   = 17'(BASE_ADDR + NUM_REGS);
   localparam logic [15:0] DEPTH_M1 = 16'(SAMPLE_DEPTH - 1);

   logic [16:0] addr_ext;
   logic        hit;
   logic [2:0]  offset;
   logic        wr_hit;
   logic [15:0] rd_val;

   assign addr_ext = {1'b0, addr_i};
   assign hit      = valid_i && (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
   assign offset   = 3'(addr_i - 16'(BASE_ADDR));
   assign wr_hit   = hit && rw_i;

   // Strobes act on the cycle the bus transfer is presented.
   assign start = wr_hit && (offset == REG_START) && wdata_i[0];
   assign stop  = wr_hit && (offset == REG_STOP)  && wdata_i[0];

   always_comb begin
      rd_val = 16'h0000;
      case (offset)
         REG_STATE:    rd_val = 16'(state);
         REG_TRIG_LOC: rd_val = 16'(trigger_loc);
         REG_STATUS: begin
            rd_val[STATUS_TIMED_OUT_BIT]       = timed_out;
            rd_val[STATUS_FIFO_LSB +: AW + 1]  = fifo_size;
         end
         default:      rd_val = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_o      <= '0;
         wdata_o     <= '0;
         rdata_o     <= '0;
         rw_o        <= 1'b0;
         valid_o     <= 1'b0;
         trigger_loc <= '0;
      end else begin
         addr_o  <= addr_i;
         wdata_o <= wdata_i;
         rw_o    <= rw_i;
         valid_o <= valid_i;
         rdata_o <= (hit && !rw_i) ? rd_val : rdata_i;
         // Position is frozen while a run is in progress.
         if (wr_hit && (offset == REG_TRIG_LOC) && (state == ST_IDLE)) begin
            trigger_loc <= (wdata_i > DEPTH_M1) ? cnt_t'(DEPTH_M1) : cnt_t'(wdata_i);
         end
      end
   end

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer acquisition sequencer: positions the trigger inside the sample buffer.
// Optional auto-trigger timeout in IN_POSITION is built when LA_CTRL_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | disarmed, waiting for START
// MOVE       | filling trigger_loc pre-trigger samples
// IN_POS     | sliding pre-trigger window (acquire+pop) until trigger
// CAPTURING  | collecting post-trigger samples
// CAPTURED   | buffer full, waiting for STOP
module la_capture_ctrl
   import la_ctrl_pkg::*;
#(
   parameter int BASE_ADDR      = 0,
   parameter int SAMPLE_DEPTH   = 1024,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           trig,
   input  logic [$clog2(SAMPLE_DEPTH):0]  fifo_size,
   output logic                           acquire,
   output logic                           pop,
   output logic                           clear,
   input  logic [15:0]                    addr_i,
   input  logic [15:0]                    wdata_i,
   input  logic [15:0]                    rdata_i,
   input  logic                           rw_i,
   input  logic                           valid_i,
   output logic [15:0]                    addr_o,
   output logic [15:0]                    wdata_o,
   output logic [15:0]                    rdata_o,
   output logic                           rw_o,
   output logic                           valid_o
);

   localparam int AW = $clog2(SAMPLE_DEPTH);
   typedef logic [AW:0] cnt_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   la_state_t state;
   cnt_t      pre_cnt;
   cnt_t      post_cnt;
   cnt_t      trigger_loc;
   cnt_t      post_target;
   logic      start;
   logic      stop;
   logic      timed_out;
   logic      to_hit;
   logic      trig_eff;
   logic [1:0] rst_pipe;
   logic       rst_int;

   // Reset asserts immediately, releases two clocks after rst drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_pipe <= 2'b11;
      else     rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_int = rst_pipe[1];

   la_ctrl_regs #(
      .BASE_ADDR    (BASE_ADDR),
      .SAMPLE_DEPTH (SAMPLE_DEPTH)
   ) u_regs (
      .clk         (clk),
      .rst         (rst_int),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rdata_i     (rdata_i),
      .rw_i        (rw_i),
      .valid_i     (valid_i),
      .addr_o      (addr_o),
      .wdata_o     (wdata_o),
      .rdata_o     (rdata_o),
      .rw_o        (rw_o),
      .valid_o     (valid_o),
      .state       (state),
      .timed_out   (timed_out),
      .fifo_size   (fifo_size),
      .trigger_loc (trigger_loc),
      .start       (start),
      .stop        (stop)
   );

`ifdef LA_CTRL_TIMEOUT_EN
   logic [31:0] to_cnt;

   assign to_hit = (state == ST_IN_POS) && (to_cnt == 32'(TIMEOUT_CYCLES - 1)) && !trig;

   // Held at zero outside IN_POS, so it starts from zero on every entry.
   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         to_cnt    <= '0;
         timed_out <= 1'b0;
      end else begin
         to_cnt <= (state == ST_IN_POS) ? to_cnt + 32'd1 : 32'd0;
         if (to_hit)
            timed_out <= 1'b1;
         else if (start && (state == ST_IDLE))
            timed_out <= 1'b0;
      end
   end
`else
   assign to_hit    = 1'b0;
   assign timed_out = 1'b0;
`endif

   assign trig_eff    = trig | to_hit;
   assign post_target = cnt_t'(SAMPLE_DEPTH) - trigger_loc;
   assign acquire     = (state == ST_MOVE) || (state == ST_IN_POS) || (state == ST_CAPTURING);
   assign pop         = (state == ST_IN_POS) && !trig_eff;

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state    <= ST_IDLE;
         pre_cnt  <= '0;
         post_cnt <= '0;
         clear    <= 1'b0;
      end else begin
         clear <= 1'b0;
         if (stop) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     clear   <= 1'b1;
                     pre_cnt <= '0;
                     state   <= (trigger_loc == '0) ? ST_IN_POS : ST_MOVE;
                  end
               end
               ST_MOVE: begin
                  pre_cnt <= pre_cnt + cnt_t'(1);
                  if (pre_cnt == trigger_loc - cnt_t'(1)) state <= ST_IN_POS;
               end
               ST_IN_POS: begin
                  if (trig_eff) begin
                     post_cnt <= cnt_t'(1);
                     state    <= (post_target == cnt_t'(1)) ? ST_CAPTURED : ST_CAPTURING;
                  end
               end
               ST_CAPTURING: begin
                  post_cnt <= post_cnt + cnt_t'(1);
                  if (post_cnt == post_target - cnt_t'(1)) state <= ST_CAPTURED;
               end
               ST_CAPTURED: state <= ST_CAPTURED;
               default:     state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Scoreboard bench for la_capture_ctrl: bus transfers and acquisition runs are
// queued with hand-computed results and checked by an independent monitor.
module tb_la_capture_ctrl;

   localparam int BASE  = 8;
   localparam int DEPTH = 16;
`ifdef LA_CTRL_TIMEOUT_EN
   localparam int TO_CYC = 40;
`else
   localparam int TO_CYC = 65535;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        trig;
   logic [4:0]  fifo_size;
   logic        acquire, pop, clear;
   logic [15:0] addr_i, wdata_i, rdata_i;
   logic        rw_i, valid_i;
   logic [15:0] addr_o, wdata_o, rdata_o;
   logic        rw_o, valid_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [15:0] wdata;
      logic [15:0] rdata;
      string       name;
   } bus_exp_t;

   typedef struct {
      int    acq;
      int    pops;
      int    clears;
      string name;
   } run_exp_t;

   bus_exp_t bus_q[$];
   run_exp_t run_q[$];

   la_capture_ctrl #(
      .BASE_ADDR      (BASE),
      .SAMPLE_DEPTH   (DEPTH),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .trig      (trig),
      .fifo_size (fifo_size),
      .acquire   (acquire),
      .pop       (pop),
      .clear     (clear),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_i   (rdata_i),
      .rw_i      (rw_i),
      .valid_i   (valid_i),
      .addr_o    (addr_o),
      .wdata_o   (wdata_o),
      .rdata_o   (rdata_o),
      .rw_o      (rw_o),
      .valid_o   (valid_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] pat(input logic [15:0] a);
      return 16'h5A00 ^ a;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [15:0] a, input logic rw, input logic [15:0] d,
                       input logic [15:0] exp_rd, input string nm);
      bus_exp_t e;
      e.addr = a; e.rw = rw; e.wdata = d; e.rdata = exp_rd; e.name = nm;
      bus_q.push_back(e);
      addr_i = a; rw_i = rw; wdata_i = d; rdata_i = pat(a); valid_i = 1'b1;
      tick(1);
      valid_i = 1'b0; rw_i = 1'b0;
   endtask

   task automatic wr(input int off, input logic [15:0] d, input string nm);
      logic [15:0] a;
      a = 16'(BASE + off);
      xfer(a, 1'b1, d, pat(a), nm);
   endtask

   task automatic rd(input int a, input logic [15:0] exp, input string nm);
      xfer(16'(a), 1'b0, 16'h0000, exp, nm);
   endtask

   task automatic expect_run(input int a, input int p, input int c, input string nm);
      run_exp_t r;
      r.acq = a; r.pops = p; r.clears = c; r.name = nm;
      run_q.push_back(r);
   endtask

   // Called right after START: trig held high for the k-th cycle of the run.
   task automatic trig_at(input int k);
      tick(k - 1);
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
   endtask

   int  acq_n = 0, pop_n = 0, clr_n = 0;
   logic acq_prev = 1'b0;

   always @(negedge clk) begin
      if (valid_o) begin
         if (bus_q.size() == 0) begin
            chk("bus_unexpected_valid", 32'(valid_o), 32'd0);
         end else begin
            bus_exp_t e;
            e = bus_q.pop_front();
            chk({e.name, "_addr"},  32'(addr_o),  32'(e.addr));
            chk({e.name, "_rw"},    32'(rw_o),    32'(e.rw));
            chk({e.name, "_wdata"}, 32'(wdata_o), 32'(e.wdata));
            chk({e.name, "_rdata"}, 32'(rdata_o), 32'(e.rdata));
         end
      end
      if (acquire) acq_n++;
      if (pop)     pop_n++;
      if (clear)   clr_n++;
      if (acq_prev && !acquire) begin
         if (run_q.size() == 0) begin
            chk("run_unexpected", 32'(acq_n), 32'd0);
         end else begin
            run_exp_t r;
            r = run_q.pop_front();
            chk({r.name, "_acquires"}, 32'(acq_n), 32'(r.acq));
            chk({r.name, "_pops"},     32'(pop_n), 32'(r.pops));
            chk({r.name, "_net"},      32'(acq_n - pop_n), 32'(r.acq - r.pops));
            chk({r.name, "_clears"},   32'(clr_n), 32'(r.clears));
         end
         acq_n = 0; pop_n = 0; clr_n = 0;
      end
      acq_prev = acquire;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; trig = 1'b0; valid_i = 1'b0; rw_i = 1'b0;
      addr_i = '0; wdata_i = '0; rdata_i = '0; fifo_size = 5'd16;
      tick(3);
      chk("rst_acquire", 32'(acquire), 32'd0);
      chk("rst_pop",     32'(pop),     32'd0);
      chk("rst_clear",   32'(clear),   32'd0);
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_rdata_o", 32'(rdata_o), 32'd0);
      rst = 1'b0;
      tick(4);

      rd(BASE + 0, 16'd0,  "rst_state");
      rd(BASE + 1, 16'd0,  "rst_loc");
      rd(BASE + 4, 16'd32, "rst_status");
      rd(BASE + 9, pat(16'(BASE + 9)), "pass_hi");
      rd(BASE - 1, pat(16'(BASE - 1)), "pass_lo");
      xfer(16'd40, 1'b1, 16'h0001, pat(16'd40), "pass_wr");

      // loc=4, trigger on 10th IN_POSITION cycle (run cycle 14)
      wr(1, 16'd4, "t1_wr_loc");
      rd(BASE + 1, 16'd4, "t1_rd_loc");
      expect_run(25, 9, 1, "t1");
      wr(2, 16'd1, "t1_start");
      trig_at(14);
      tick(15);
      rd(BASE + 0, 16'd4,  "t1_captured");
      rd(BASE + 4, 16'd32, "t1_status");
      wr(3, 16'd1, "t1_stop");
      rd(BASE + 0, 16'd0,  "t1_idle");

      // loc=0: straight into IN_POSITION
      wr(1, 16'd0, "t2_wr_loc");
      expect_run(18, 2, 1, "t2");
      wr(2, 16'd1, "t2_start");
      trig_at(3);
      tick(20);
      rd(BASE + 0, 16'd4, "t2_captured");
      wr(3, 16'd1, "t2_stop");

      // saturating position, single post sample
      wr(1, 16'd100, "t3_wr_loc");
      rd(BASE + 1, 16'd15, "t3_rd_loc");
      expect_run(17, 1, 1, "t3");
      wr(2, 16'd1, "t3_start");
      trig_at(17);
      tick(5);
      rd(BASE + 0, 16'd4, "t3_captured");
      wr(1, 16'd3, "t3_wr_loc_busy");
      rd(BASE + 1, 16'd15, "t3_loc_kept");
      wr(3, 16'd1, "t3_stop");
      rd(BASE + 0, 16'd0, "t3_idle");

      // STOP mid-capture, then rerun
      wr(1, 16'd4, "t4_wr_loc");
      expect_run(9, 1, 1, "t4_abort");
      wr(2, 16'd1, "t4_start");
      trig_at(6);
      tick(2);
      wr(3, 16'd1, "t4_stop");
      rd(BASE + 0, 16'd0, "t4_idle");
      expect_run(16, 0, 1, "t4_rerun");
      wr(2, 16'd1, "t4_restart");
      trig_at(5);
      tick(15);
      rd(BASE + 0, 16'd4, "t4_captured");
      wr(3, 16'd1, "t4_stop2");

`ifdef LA_CTRL_TIMEOUT_EN
      wr(1, 16'd0, "t5_wr_loc");
      expect_run(55, 39, 1, "t5_timeout");
      wr(2, 16'd1, "t5_start");
      tick(60);
      rd(BASE + 4, 16'd33, "t5_status_to");
      rd(BASE + 0, 16'd4,  "t5_captured");
      wr(3, 16'd1, "t5_stop");
      expect_run(16, 0, 1, "t5_rerun");
      wr(2, 16'd1, "t5_restart");
      trig_at(1);
      tick(20);
      rd(BASE + 4, 16'd32, "t5_status_clr");
      wr(3, 16'd1, "t5_stop2");
`endif

      // reset during MOVE_TO_POSITION
      wr(1, 16'd4, "t6_wr_loc");
      expect_run(2, 0, 1, "t6_rst");
      wr(2, 16'd1, "t6_start");
      tick(2);
      rst = 1'b1;
      #1;
      chk("t6_acquire", 32'(acquire), 32'd0);
      chk("t6_pop",     32'(pop),     32'd0);
      chk("t6_clear",   32'(clear),   32'd0);
      chk("t6_valid_o", 32'(valid_o), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(4);
      rd(BASE + 0, 16'd0, "t6_state");
      rd(BASE + 1, 16'd0, "t6_loc");

      tick(5);
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("run_q_drained", 32'(run_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
